lap_controller: RTL and testbench
=================================

# lap_controller

Lap-time controller for the stopwatch: sits between the stopwatch counter and the BCD/7-segment display path. It captures lap times on the debounced lap button into a small lap memory and freezes the captured lap on the display for a hold period. While the stopwatch is paused, repeated lap presses step through the stored laps, and the clear button empties the memory. It drives the hour/minute/second/m_sec values that the display chain converts, in place of the raw timer outputs.

## Interface
- DEPTH, 8: lap memory slots, 1..15.
- HOLD_CYCLES, 100_000_000: cycles a captured lap stays frozen on the display (2 s at 50 MHz); ≥ 2.
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- lap  in  1  debounced lap button, active-high level.
- clear  in  1  debounced clear button, active-high level.
- run  in  1  stopwatch running (run_timer from the key FSM).
- hour  in  6  live hours.
- minute  in  6  live minutes.
- second  in  6  live seconds.
- m_sec  in  7  live hundredths.
- disp_hour  out  6  displayed hours.
- disp_minute  out  6  displayed minutes.
- disp_second  out  6  displayed seconds.
- disp_m_sec  out  7  displayed hundredths.
- showing_lap  out  1  1 when a stored or frozen lap is displayed.
- lap_number  out  4  1-based number of the displayed lap; 0 when the display shows the live time.
- lap_count  out  4  laps stored, 0..DEPTH.
- full  out  1  lap_count == DEPTH.

## Operation
- Edge detect: lap_q and clear_q are registered copies of lap and clear, both reset to 0.
  - lap_rise = lap & ~lap_q.
  - clear_rise = clear & ~clear_q.
- Lap memory: DEPTH × 25 bits, stored as {hour, minute, second, m_sec}. Writes go to slot lap_count. Contents are undefined after reset and are never read before they are written.
- States: LIVE, HOLD, RECALL. Reset state is LIVE.
- clear_rise has top priority in every state:
  - lap_count becomes 0 and the state becomes LIVE.
  - A lap_rise in the same cycle is ignored.
- LIVE (display = live inputs, showing_lap = 0, lap_number = 0):
  - lap_rise & run & ~full: write the live inputs to slot lap_count, load the snapshot register with the same inputs, increment lap_count, load hold_cnt = HOLD_CYCLES−1, go to HOLD.
  - lap_rise & run & full: ignored; stay in LIVE.
  - lap_rise & ~run & lap_count > 0: rd_idx = 0, go to RECALL.
  - lap_rise & ~run & lap_count == 0: ignored.
- HOLD (display = snapshot, showing_lap = 1, lap_number = lap_count):
  - hold_cnt decrements every cycle.
  - The cycle hold_cnt == 0 transitions to LIVE.
  - lap_rise & run & ~full: capture exactly as in LIVE and restart hold_cnt.
  - lap_rise while full: ignored; hold continues.
  - A change of run does not affect HOLD.
- RECALL (display = mem[rd_idx], showing_lap = 1, lap_number = rd_idx+1):
  - lap_rise: if rd_idx == lap_count−1, go to LIVE; otherwise rd_idx increments.
  - run == 1: go to LIVE immediately. This has priority over lap_rise.
- Display sourcing: disp_* are registered. Each cycle they load from the source selected by the state and the register values at that clock edge.

## Timing
- Reset values: all disp_* = 0, showing_lap = 0, lap_number = 0, lap_count = 0, full = 0, state LIVE, hold_cnt = 0, rd_idx = 0.
- Live passthrough latency: 1 cycle from the inputs to disp_*.
- Capture: the stored value equals the inputs sampled on the edge where lap_rise is true. On the following edge, disp_* show the snapshot and showing_lap = 1.
- Hold duration: showing_lap stays 1 for exactly HOLD_CYCLES cycles after the capture edge. The live time reappears 1 cycle after that.
- Recall step: disp_* update 1 cycle after the edge that increments rd_idx (registered read).
- A lap level held high produces exactly one lap_rise. Re-arming requires the input to return low.
- Asynchronous reset mid-HOLD or mid-RECALL: all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
Simulate with DEPTH = 4 and HOLD_CYCLES = 10.
- Reset, then run = 1 with the inputs at 0:01:02.34, pulse lap → stored value 0:01:02.34; the display stays frozen for 10 cycles with lap_number = 1 and lap_count = 1, then returns to live.
- With run = 1, take 4 laps, then a 5th → full = 1 and lap_count = 4; the 5th press is ignored and the state stays LIVE.
- run = 0 with 3 laps stored: 4 lap pulses → lap_number steps 1, 2, 3, then the live time with lap_number = 0; each display matches its stored value.
- In RECALL at lap 2, set run = 1 → LIVE on the next edge and showing_lap = 0 one cycle later.
- Rising edges of clear and lap in the same cycle during HOLD → lap_count = 0, state LIVE, nothing stored.
- Assert reset mid-HOLD with no clock edge → disp_* = 0, showing_lap = 0, lap_count = 0 immediately.

Source files
------------

// File: rtl/lap_controller.sv
// Lap-time controller between the stopwatch counter and the display chain.
// Captures laps into a small memory, freezes them on display and lets the user browse them while paused.
module lap_controller #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lap,
    input  logic       clear,
    input  logic       run,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [6:0] m_sec,
    output logic [5:0] disp_hour,
    output logic [5:0] disp_minute,
    output logic [5:0] disp_second,
    output logic [6:0] disp_m_sec,
    output logic       showing_lap,
    output logic [3:0] lap_number,
    output logic [3:0] lap_count,
    output logic       full
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [3:0]        DEPTH_L   = 4'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        LIVE,
        HOLD,
        RECALL
    } state_t;

    state_t            state_reg;
    logic              lap_q_reg;
    logic              clear_q_reg;
    logic [3:0]        lap_count_reg;
    logic [3:0]        rd_idx_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [24:0]       snap_reg;
    logic [24:0]       disp_reg;
    logic              showing_reg;
    logic [3:0]        lap_number_reg;

    logic [24:0] mem [0:DEPTH-1];

    logic [24:0] live_time;
    logic        lap_rise;
    logic        clear_rise;
    logic        is_full;
    logic        capture;

    assign live_time  = {hour, minute, second, m_sec};
    assign lap_rise   = lap & ~lap_q_reg;
    assign clear_rise = clear & ~clear_q_reg;
    assign is_full    = (lap_count_reg == DEPTH_L);

    // A capture is possible from LIVE or HOLD; clear wins over a simultaneous lap press.
    assign capture = lap_rise & run & ~is_full & ~clear_rise & (state_reg != RECALL);

    // Lap memory: plain write port, no reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (capture) begin
            mem[lap_count_reg[IDX_W-1:0]] <= live_time;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= LIVE;
            lap_q_reg      <= 1'b0;
            clear_q_reg    <= 1'b0;
            lap_count_reg  <= '0;
            rd_idx_reg     <= '0;
            hold_cnt_reg   <= '0;
            snap_reg       <= '0;
            disp_reg       <= '0;
            showing_reg    <= 1'b0;
            lap_number_reg <= '0;
        end else begin
            lap_q_reg   <= lap;
            clear_q_reg <= clear;

            // Display source follows the state held before this edge.
            case (state_reg)
                HOLD: begin
                    disp_reg       <= snap_reg;
                    showing_reg    <= 1'b1;
                    lap_number_reg <= lap_count_reg;
                end
                RECALL: begin
                    disp_reg       <= mem[rd_idx_reg[IDX_W-1:0]];
                    showing_reg    <= 1'b1;
                    lap_number_reg <= rd_idx_reg + 4'd1;
                end
                default: begin
                    disp_reg       <= live_time;
                    showing_reg    <= 1'b0;
                    lap_number_reg <= '0;
                end
            endcase

            if (clear_rise) begin
                lap_count_reg <= '0;
                state_reg     <= LIVE;
            end else begin
                case (state_reg)
                    LIVE: begin
                        if (capture) begin
                            snap_reg      <= live_time;
                            lap_count_reg <= lap_count_reg + 4'd1;
                            hold_cnt_reg  <= HOLD_LOAD;
                            state_reg     <= HOLD;
                        end else if (lap_rise && !run && lap_count_reg != 4'd0) begin
                            rd_idx_reg <= '0;
                            state_reg  <= RECALL;
                        end
                    end
                    HOLD: begin
                        if (capture) begin
                            snap_reg      <= live_time;
                            lap_count_reg <= lap_count_reg + 4'd1;
                            hold_cnt_reg  <= HOLD_LOAD;
                        end else if (hold_cnt_reg == '0) begin
                            state_reg <= LIVE;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - 1'b1;
                        end
                    end
                    RECALL: begin
                        // Restarting the stopwatch abandons browsing immediately.
                        if (run) begin
                            state_reg <= LIVE;
                        end else if (lap_rise) begin
                            if (rd_idx_reg == lap_count_reg - 4'd1) begin
                                state_reg <= LIVE;
                            end else begin
                                rd_idx_reg <= rd_idx_reg + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= LIVE;
                    end
                endcase
            end
        end
    end

    assign {disp_hour, disp_minute, disp_second, disp_m_sec} = disp_reg;
    assign showing_lap = showing_reg;
    assign lap_number  = lap_number_reg;
    assign lap_count   = lap_count_reg;
    assign full        = is_full;

endmodule

// File: tb/tb_lap_controller.sv
// Self-checking bench for lap_controller: directed scenarios plus random presses,
// all compared against a lap-list reference model.
module tb_lap_controller;

    localparam int DEPTH = 4;
    localparam int HOLD  = 10;

    localparam int M_LIVE   = 0;
    localparam int M_FROZEN = 1;
    localparam int M_BROWSE = 2;

    logic       clock;
    logic       reset;
    logic       lap;
    logic       clear;
    logic       run;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [6:0] m_sec;
    logic [5:0] disp_hour;
    logic [5:0] disp_minute;
    logic [5:0] disp_second;
    logic [6:0] disp_m_sec;
    logic       showing_lap;
    logic [3:0] lap_number;
    logic [3:0] lap_count;
    logic       full;

    lap_controller #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .lap         (lap),
        .clear       (clear),
        .run         (run),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .m_sec       (m_sec),
        .disp_hour   (disp_hour),
        .disp_minute (disp_minute),
        .disp_second (disp_second),
        .disp_m_sec  (disp_m_sec),
        .showing_lap (showing_lap),
        .lap_number  (lap_number),
        .lap_count   (lap_count),
        .full        (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of stored laps, a display mode and the edge at which a freeze began.
    logic [24:0] laps[$];
    int          mode;
    int          hold_start;
    int          br_idx;
    logic [24:0] snap;
    logic        prev_lap;
    logic        prev_clear;
    int          edge_n;
    logic [24:0] exp_disp;
    logic        exp_show;
    int          exp_num;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        laps.delete();
        mode       = M_LIVE;
        hold_start = 0;
        br_idx     = 0;
        snap       = '0;
        prev_lap   = 1'b0;
        prev_clear = 1'b0;
        edge_n     = 0;
    endtask

    task automatic model_edge();
        logic [24:0] live;
        logic        lr;
        logic        cr;
        live = {hour, minute, second, m_sec};
        lr   = lap & ~prev_lap;
        cr   = clear & ~prev_clear;
        edge_n++;

        if (mode == M_FROZEN) begin
            exp_disp = snap;
            exp_show = 1'b1;
            exp_num  = laps.size();
        end else if (mode == M_BROWSE) begin
            exp_disp = laps[br_idx];
            exp_show = 1'b1;
            exp_num  = br_idx + 1;
        end else begin
            exp_disp = live;
            exp_show = 1'b0;
            exp_num  = 0;
        end

        if (cr) begin
            laps.delete();
            mode = M_LIVE;
        end else if (mode == M_BROWSE) begin
            if (run)
                mode = M_LIVE;
            else if (lr) begin
                if (br_idx == laps.size() - 1)
                    mode = M_LIVE;
                else
                    br_idx++;
            end
        end else if (lr && run && laps.size() < DEPTH) begin
            laps.push_back(live);
            snap       = live;
            mode       = M_FROZEN;
            hold_start = edge_n;
        end else if (mode == M_LIVE && lr && !run && laps.size() > 0) begin
            mode   = M_BROWSE;
            br_idx = 0;
        end else if (mode == M_FROZEN && edge_n - hold_start >= HOLD) begin
            mode = M_LIVE;
        end

        prev_lap   = lap;
        prev_clear = clear;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        check("disp", {disp_hour, disp_minute, disp_second, disp_m_sec}, exp_disp);
        check("showing_lap", showing_lap, exp_show);
        check("lap_number", lap_number, exp_num);
        check("lap_count", lap_count, laps.size());
        check("full", full, laps.size() == DEPTH);
    endtask

    task automatic set_time(input logic [24:0] t);
        {hour, minute, second, m_sec} = t;
    endtask

    task automatic press();
        lap = 1'b1;
        step();
        lap = 1'b0;
        step();
    endtask

    initial begin
        logic [24:0] lap1;
        logic [24:0] vals [0:2];
        int          shown;

        lap1    = {6'd0, 6'd1, 6'd2, 7'd34};
        vals[0] = {6'd1, 6'd10, 6'd20, 7'd11};
        vals[1] = {6'd2, 6'd22, 6'd33, 7'd44};
        vals[2] = {6'd3, 6'd35, 6'd48, 7'd99};

        reset = 1'b1;
        lap   = 1'b0;
        clear = 1'b0;
        run   = 1'b0;
        set_time('0);
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        check("rst_disp", {disp_hour, disp_minute, disp_second, disp_m_sec}, 25'd0);
        check("rst_showing", showing_lap, 1'b0);
        check("rst_lap_number", lap_number, 4'd0);
        check("rst_lap_count", lap_count, 4'd0);
        check("rst_full", full, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();

        // First capture and hold length
        run = 1'b1;
        set_time(lap1);
        lap = 1'b1;
        step();
        lap = 1'b0;
        set_time({6'd5, 6'd6, 6'd7, 7'd8});
        step();
        check("frozen_val", {disp_hour, disp_minute, disp_second, disp_m_sec}, lap1);
        check("frozen_num", lap_number, 4'd1);
        shown = showing_lap ? 1 : 0;
        repeat (11) begin
            step();
            if (showing_lap) shown++;
        end
        check("hold_len", shown, HOLD);
        check("live_back", {disp_hour, disp_minute, disp_second, disp_m_sec}, {6'd5, 6'd6, 6'd7, 7'd8});
        $display("capture: lap 1 frozen for %0d cycles", shown);

        // Fill memory, then a fifth press once the hold has expired
        repeat (3) press();
        repeat (12) step();
        check("full_flag", full, 1'b1);
        press();
        check("full_count", lap_count, 4'd4);
        check("full_ignored_live", showing_lap, 1'b0);
        $display("full: lap_count=%0d full=%0d", lap_count, full);

        // Recall three stored laps
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            set_time(vals[i]);
            press();
        end
        set_time({6'd9, 6'd9, 6'd9, 7'd9});
        repeat (12) step();
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            press();
            check("recall_num", lap_number, (k < 3) ? k + 1 : 0);
            if (k < 3)
                check("recall_val", {disp_hour, disp_minute, disp_second, disp_m_sec}, vals[k]);
            else
                check("recall_live", {disp_hour, disp_minute, disp_second, disp_m_sec}, {6'd9, 6'd9, 6'd9, 7'd9});
            $display("recall press %0d: lap_number=%0d", k + 1, lap_number);
        end

        // Run restart while browsing lap 2
        press();
        press();
        check("recall_at2", lap_number, 4'd2);
        run = 1'b1;
        step();
        check("run_exit_edge", showing_lap, 1'b1);
        step();
        check("run_exit_live", showing_lap, 1'b0);
        $display("recall exit on run: showing_lap=%0d", showing_lap);

        // Clear and lap rising together during HOLD
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        press();
        clear = 1'b1;
        lap   = 1'b1;
        step();
        check("clr_lap_count", lap_count, 4'd0);
        clear = 1'b0;
        lap   = 1'b0;
        step();
        check("clr_lap_live", showing_lap, 1'b0);
        check("clr_lap_count2", lap_count, 4'd0);
        $display("clear+lap: lap_count=%0d", lap_count);

        // Asynchronous reset in the middle of a hold
        set_time({6'd4, 6'd44, 6'd44, 7'd44});
        press();
        step();
        #3;
        reset = 1'b1;
        #1;
        check("areset_disp", {disp_hour, disp_minute, disp_second, disp_m_sec}, 25'd0);
        check("areset_showing", showing_lap, 1'b0);
        check("areset_count", lap_count, 4'd0);
        check("areset_num", lap_number, 4'd0);
        #1;
        reset = 1'b0;
        model_reset();
        $display("async reset mid-hold: showing_lap=%0d lap_count=%0d", showing_lap, lap_count);

        // Random presses, run changes and clears
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) lap = ~lap;
            if ($urandom_range(0, 15) == 0) run = ~run;
            clear  = ($urandom_range(0, 39) == 0);
            hour   = 6'($urandom);
            minute = 6'($urandom);
            second = 6'($urandom);
            m_sec  = 7'($urandom);
            step();
        end
        $display("random: 3000 cycles, final lap_count=%0d", lap_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
